// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the nibble-serial ALU controller and its 4-bit slice.
//   state_e   : controller state encoding (IDLE / RUN / DONE)
//   OP_*      : 2-bit Op field of the ALU control word
//   CTRL_*    : complete 4-bit control words {Ainvert, Binvert, Op[1:0]}
//               for the common operations, including SUB and NOR
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

endpackage

// File: rtl/alu_nibble_seq_alu_4b.sv
// alu_nibble_seq_alu_4b
// Purely combinational 4-bit ALU slice built from four 1-bit cells with a
// ripple carry chain.
// Ports:
//   a_i, b_i     [3:0] operand nibbles
//   ainvert_i          invert A before the operation
//   binvert_i          invert B before the operation
//   carry_i            carry into bit 0
//   less_i             value placed on bit 0 for Op=11 (set-less-than cell)
//   op_i         [1:0] 00 AND, 01 OR, 10 ADD, 11 LESS
//   y_o          [3:0] slice result
//   carry_o            carry out of bit 3
module alu_nibble_seq_alu_4b
  import alu_seq_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ainvert_i,
  input  logic       binvert_i,
  input  logic       carry_i,
  input  logic       less_i,
  input  logic [1:0] op_i,
  output logic [3:0] y_o,
  output logic       carry_o
);

  logic [3:0] a_eff;
  logic [3:0] b_eff;
  logic [3:0] sum;
  logic [4:0] c;

  assign a_eff = ainvert_i ? ~a_i : a_i;
  assign b_eff = binvert_i ? ~b_i : b_i;
  assign c[0]  = carry_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign sum[gi]  = a_eff[gi] ^ b_eff[gi] ^ c[gi];
      assign c[gi+1]  = (a_eff[gi] & b_eff[gi]) | (c[gi] & (a_eff[gi] ^ b_eff[gi]));
    end
  endgenerate

  always_comb begin
    y_o = 4'b0000;
    case (op_i)
      OP_AND:  y_o = a_eff & b_eff;
      OP_OR:   y_o = a_eff | b_eff;
      OP_ADD:  y_o = sum;
      default: y_o = {3'b000, less_i};
    endcase
  end

  assign carry_o = c[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
// Runs an XLEN-bit ALU operation through a single 4-bit slice, one nibble per
// clock, least significant nibble first. Latency is XLEN/4 + 1 cycles for
// every operation; done pulses for one cycle when result and flags update.
// Configuration macro: ALU_NIBBLE_SEQ_SLT_EN
//   defined   : Op=11 is signed set-less-than
//   undefined : Op=11 runs the same sequence but reports result 0, zero 1,
//               carry_out 0, overflow 0
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           operation request, sampled only while idle
//   a, b            XLEN-bit operands
//   alu_ctrl        {Ainvert, Binvert, Op[1:0]}
//   busy            high while nibbles are being processed
//   done            one-cycle completion pulse
//   result          XLEN-bit result, held until the next completion
//   zero, carry_out, overflow  flags belonging to result
// XLEN must be a multiple of 4 and at least 8.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            carry_out,
  output logic            overflow
);

  localparam int NIB   = XLEN / 4;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_sh_q, a_sh_d;
  logic [XLEN-1:0]   b_sh_q, b_sh_d;
  // Upper result nibbles collected so far; the slice output completes it.
  logic [XLEN-5:0]   res_sh_q, res_sh_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;

  logic              ainv;
  logic              binv;
  logic [1:0]        op;
  logic [1:0]        slice_op;
  logic              slice_cin;
  logic [3:0]        slice_y;
  logic              slice_co;
  logic [XLEN-1:0]   res_full;
  logic              sum_msb;
  logic              a_msb;
  logic              b_eff_msb;
  logic              ovf_raw;
  logic [XLEN-1:0]   res_final;
  logic              fin_carry;
  logic              fin_ovf;

  assign ainv = ctrl_q[3];
  assign binv = ctrl_q[2];
  assign op   = ctrl_q[1:0];

  // SLT is computed as a subtraction; the less bit is formed here, not in
  // the slice, so the slice never sees Op=11.
  assign slice_op  = (op == OP_SLT) ? OP_ADD : op;
  // The +1 of a two's complement subtract enters as the first carry-in.
  assign slice_cin = (idx_q == '0) ? binv : carry_q;

  alu_nibble_seq_alu_4b u_slice (
    .a_i       (a_sh_q[3:0]),
    .b_i       (b_sh_q[3:0]),
    .ainvert_i (ainv),
    .binvert_i (binv),
    .carry_i   (slice_cin),
    .less_i    (1'b0),
    .op_i      (slice_op),
    .y_o       (slice_y),
    .carry_o   (slice_co)
  );

  assign res_full = {slice_y, res_sh_q};

  // Only meaningful on the last nibble, where the shift registers hold the
  // operand MSBs and the slice produces the sum MSB.
  assign sum_msb   = slice_y[3];
  assign a_msb     = a_sh_q[3];
  assign b_eff_msb = b_sh_q[3] ^ binv;
  assign ovf_raw   = (a_msb == b_eff_msb) && (sum_msb != a_msb);

  always_comb begin
    res_final = res_full;
    fin_carry = 1'b0;
    fin_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        fin_carry = slice_co;
        fin_ovf   = ovf_raw;
      end
      OP_SLT: begin
`ifdef ALU_NIBBLE_SEQ_SLT_EN
        res_final = {{(XLEN-1){1'b0}}, sum_msb ^ ovf_raw};
        fin_carry = slice_co;
        fin_ovf   = ovf_raw;
`else
        res_final = '0;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    ctrl_d      = ctrl_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          ctrl_d  = alu_ctrl;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = {4'b0000, a_sh_q[XLEN-1:4]};
        b_sh_d   = {4'b0000, b_sh_q[XLEN-1:4]};
        res_sh_d = res_full[XLEN-1:4];
        carry_d  = slice_co;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Visible outputs update only here, so partial results never leak.
          result_d    = res_final;
          zero_d      = (res_final == '0);
          carry_out_d = fin_carry;
          overflow_d  = fin_ovf;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      ctrl_q      <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      ctrl_q      <= ctrl_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
